// File: rtl/sa_pkg.sv
// sa_pkg
//   Shared types and helpers for the systolic-array tile sequencer.
//   - sa_seq_state_e : sequencer FSM state encoding
//   - drain_cycles() : cycles from the last accepted beat until every cell
//                      has folded its final product into its accumulator
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sa_seq_state_e;

  // The last beat needs ROWS+COLS-1 hops to reach the far corner cell.
  // After that it needs MAC_LAT cycles to multiply, one cycle to write the
  // accumulator, and ACC_STAGES valid stages. One more cycle gives margin so
  // that done is never seen before the corner result has settled.
  function automatic int drain_cycles(input int rows, input int cols,
                                      input int mac_lat, input int acc_stages);
    return rows + cols - 1 + mac_lat + 1 + acc_stages + 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line
//   Fixed-depth shift register carrying a {valid, data} pair. It delays one
//   array-edge lane by DEPTH cycles. The synchronous flush clears every
//   stage so that an aborted job leaves no valid beats in flight.
// Ports
//   clk       in   1     clock
//   rst_n     in   1     async active-low reset
//   flush     in   1     sync clear of all stages (wins over shifting)
//   in_vld    in   1     lane valid entering the line
//   in_data   in   W     lane data entering the line
//   out_vld   out  1     valid after DEPTH cycles
//   out_data  out  W     data after DEPTH cycles
module sa_skew_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld_sr;
  logic [W-1:0]     data_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) data_sr[i] <= '0;
    end else if (flush) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) data_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= in_vld;
      data_sr[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        data_sr[i] <= data_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[DEPTH-1];
  assign out_data = data_sr[DEPTH-1];

endmodule

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer
//   Runs one output tile on a ROWS x COLS grid of FP8 MAC cells. It clears
//   the accumulators, then accepts k_len paired A/B operand beats with at
//   least BEAT_GAP cycles between them. It skews each beat onto the array
//   edges, waits for the pipeline to drain, and then pulses done.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start, abort               job request (IDLE only), sync job kill
//   k_len, mode_fp8_i,
//   out_bf16_i                 job config, sampled with start
//   a_vld/a_data/a_rdy         A column-vector beat (ROWS lanes of 8 bits)
//   b_vld/b_data/b_rdy         B row-vector beat (COLS lanes of 8 bits)
//   row_a_data/row_a_vld       skewed A onto the west edge (lane r delayed r+1)
//   col_b_data/col_b_vld       skewed B onto the north edge (lane c delayed c+1)
//   acc_clear, acc_en          accumulator controls broadcast to all cells
//   mode_fp8, out_bf16_en      latched format controls
//   busy, done                 not-IDLE flag, 1-cycle tile-complete pulse
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for start; outputs quiet
//   S_CLEAR  | acc_clear high for one cycle; config already latched
//   S_STREAM | acc_en high; accepting paired A/B beats, gap-limited
//   S_DRAIN  | acc_en high; last beat propagating through the array
//   S_DONE   | done pulse; acc_en low; start ignored
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_W        = 8,
  parameter int MAC_LAT    = 1,
  parameter int ACC_STAGES = 1,
  parameter int BEAT_GAP   = MAC_LAT + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [K_W-1:0]    k_len,
  input  logic              mode_fp8_i,
  input  logic              out_bf16_i,
  input  logic              a_vld,
  input  logic [ROWS*8-1:0] a_data,
  output logic              a_rdy,
  input  logic              b_vld,
  input  logic [COLS*8-1:0] b_data,
  output logic              b_rdy,
  output logic [ROWS*8-1:0] row_a_data,
  output logic [ROWS-1:0]   row_a_vld,
  output logic [COLS*8-1:0] col_b_data,
  output logic [COLS-1:0]   col_b_vld,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              mode_fp8,
  output logic              out_bf16_en,
  output logic              busy,
  output logic              done
);

  localparam int DRAIN_CYC = drain_cycles(ROWS, COLS, MAC_LAT, ACC_STAGES);
  localparam int DRAIN_W   = $clog2(DRAIN_CYC);
  localparam int GAP_W     = (BEAT_GAP > 1) ? $clog2(BEAT_GAP) : 1;

  sa_seq_state_e      state;
  logic [K_W-1:0]     k_len_q;
  logic [K_W-1:0]     beat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  logic accept;
  logic flush;
  logic last_beat;

  // A and B are consumed only as a pair, so both ready flags are the same signal.
  assign accept    = (state == S_STREAM) && a_vld && b_vld && (gap_cnt == '0);
  assign a_rdy     = accept;
  assign b_rdy     = accept;
  assign flush     = abort && (state != S_IDLE);
  assign last_beat = (beat_cnt == k_len_q - K_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      drain_cnt   <= '0;
      mode_fp8    <= 1'b0;
      out_bf16_en <= 1'b0;
      acc_clear   <= 1'b0;
      acc_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      if (flush) begin
        // Clear the accumulators on the way out so that a partial tile is never left behind.
        state     <= S_IDLE;
        acc_clear <= 1'b1;
        acc_en    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              k_len_q     <= k_len;
              mode_fp8    <= mode_fp8_i;
              out_bf16_en <= out_bf16_i;
              acc_clear   <= 1'b1;
              busy        <= 1'b1;
              state       <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            beat_cnt <= '0;
            gap_cnt  <= '0;
            acc_en   <= 1'b1;
            if (k_len_q == '0) begin
              drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
              state     <= S_DRAIN;
            end else begin
              state <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (accept) begin
              gap_cnt  <= GAP_W'(BEAT_GAP - 1);
              beat_cnt <= beat_cnt + K_W'(1);
              if (last_beat) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
                state     <= S_DRAIN;
              end
            end else if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
          S_DRAIN: begin
            if (drain_cnt == '0) begin
              acc_en <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            acc_en <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Non-accept cycles inject zeroed bubbles, so idle lanes carry no stale operands.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    sa_skew_line #(.W(8), .DEPTH(r + 1)) u_skew (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_vld   (accept),
      .in_data  (accept ? a_data[8*r +: 8] : 8'h00),
      .out_vld  (row_a_vld[r]),
      .out_data (row_a_data[8*r +: 8])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    sa_skew_line #(.W(8), .DEPTH(c + 1)) u_skew (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_vld   (accept),
      .in_data  (accept ? b_data[8*c +: 8] : 8'h00),
      .out_vld  (col_b_vld[c]),
      .out_data (col_b_data[8*c +: 8])
    );
  end

endmodule
